// File: rtl/cg_ctrl_pkg.sv
// rtl/cg_ctrl_pkg.sv - shared types and helpers for the clock gate enable sequencer
package cg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } cg_state_e;

    // One counter serves both the wake latency and the idle timeout.
    function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
        int m;
        m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cg_channel_fsm.sv
// rtl/cg_channel_fsm.sv - one channel's gate enable FSM with wake/idle counter
module cg_channel_fsm
    import cg_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic wake_req_i,
    input  logic force_on_i,
    output logic en_o,
    output logic ack_o,
    output logic is_off_o
);

    localparam int CNT_W = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    cg_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active;

    assign active = busy_i | wake_req_i | force_on_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    // Busy alone never wakes: the requester must ask first.
                    if (wake_req_i | force_on_i) begin
                        state_q <= ST_WAKE;
                        cnt_q   <= '0;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_q <= ST_ON;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!active) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_IDLE: begin
                    // Clock is still running, so activity returns straight to ON.
                    if (active) begin
                        state_q <= ST_ON;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_q <= ST_OFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign en_o     = (state_q != ST_OFF);
    assign ack_o    = (state_q == ST_ON) & wake_req_i;
    assign is_off_o = (state_q == ST_OFF);

endmodule

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - per-channel clock gate enable sequencer, always-on domain
module clock_gate_ctrl
    import cg_ctrl_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [N_CH-1:0] BUSY_I,
    input  logic [N_CH-1:0] WAKE_REQ_I,
    input  logic [N_CH-1:0] FORCE_ON_I,
    output logic [N_CH-1:0] EN_O,
    output logic [N_CH-1:0] WAKE_ACK_O,
    output logic            ALL_OFF_O
);

    logic [N_CH-1:0] is_off;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cg_channel_fsm #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES)
        ) u_fsm (
            .clk_i      (CLK_I),
            .rst_i      (RST_I),
            .busy_i     (BUSY_I[g]),
            .wake_req_i (WAKE_REQ_I[g]),
            .force_on_i (FORCE_ON_I[g]),
            .en_o       (EN_O[g]),
            .ack_o      (WAKE_ACK_O[g]),
            .is_off_o   (is_off[g])
        );
    end

    assign ALL_OFF_O = &is_off;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - directed self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busy, req, force_on;
    logic [3:0] en, ack;
    logic       all_off;
    int         n_checks = 0;
    int         n_fail = 0;

    clock_gate_ctrl #(.N_CH(4), .WAKE_CYCLES(2), .IDLE_CYCLES(16)) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .BUSY_I     (busy),
        .WAKE_REQ_I (req),
        .FORCE_ON_I (force_on),
        .EN_O       (en),
        .WAKE_ACK_O (ack),
        .ALL_OFF_O  (all_off)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; busy = '0; req = '0; force_on = '0;
        tick();
        check("rst_en", 32'(en), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_alloff", 32'(all_off), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_en", 32'(en), 32'h0);
            check("idle_ack", 32'(ack), 32'h0);
            check("idle_alloff", 32'(all_off), 32'h1);
        end

        // ch0 wake: EN after edge 1, ACK after edge 3
        req[0] = 1'b1;
        tick();
        check("w0_e1_en", 32'(en), 32'h1);
        check("w0_e1_ack", 32'(ack), 32'h0);
        check("w0_e1_alloff", 32'(all_off), 32'h0);
        tick();
        check("w0_e2_ack", 32'(ack), 32'h0);
        tick();
        check("w0_e3_ack", 32'(ack), 32'h1);
        check("w0_e3_en", 32'(en), 32'h1);

        busy[0] = 1'b1; req[0] = 1'b0;
        #1;
        check("w0_ack_drop", 32'(ack), 32'h0);
        tick(); tick();
        busy[0] = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("t0_hold_en", 32'(en), 32'h1);
        end
        tick();
        check("t0_off_en", 32'(en), 32'h0);
        check("t0_off_alloff", 32'(all_off), 32'h1);

        // ch1: activity on the exact timeout edge keeps the gate open
        req[1] = 1'b1;
        tick(); tick(); tick();
        check("w1_ack", 32'(ack), 32'h2);
        busy[1] = 1'b1; req[1] = 1'b0;
        tick();
        busy[1] = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) tick();
        check("t1_cnt15_en", 32'(en), 32'h2);
        busy[1] = 1'b1;
        tick();
        check("t1_rescue_en", 32'(en), 32'h2);
        busy[1] = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("t1_hold_en", 32'(en), 32'h2);
        end
        tick();
        check("t1_off_en", 32'(en), 32'h0);

        // ch2 forced on: no ack, never gated
        force_on[2] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("f2_en", 32'(en), 32'h4);
            check("f2_ack", 32'(ack), 32'h0);
        end
        force_on[2] = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("f2_hold_en", 32'(en), 32'h4);
        end
        tick();
        check("f2_off_en", 32'(en), 32'h0);

        // ch3: short request pulse still completes wake, then idles
        req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p3_en", 32'(en), 32'h8);
            check("p3_ack", 32'(ack), 32'h0);
        end

        // all channels ON, then reset with requests held
        req = 4'hf;
        tick(); tick(); tick();
        check("all_ack", 32'(ack), 32'hf);
        check("all_en", 32'(en), 32'hf);
        rst = 1'b1;
        tick();
        check("mid_rst_en", 32'(en), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_alloff", 32'(all_off), 32'h1);
        rst = 1'b0;
        tick();
        check("rw_e1_en", 32'(en), 32'hf);
        check("rw_e1_ack", 32'(ack), 32'h0);
        tick();
        check("rw_e2_ack", 32'(ack), 32'h0);
        tick();
        check("rw_e3_ack", 32'(ack), 32'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
